// File: rtl/phy_data_scoreboard.sv
// phy_data_scoreboard: end-to-end tx->rx data checker with latency lock.
// Queues tx words with ages, matches rx words, tracks pass/fail counts.
module phy_data_scoreboard #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int DEPTH          = 8,
  parameter int MAX_LATENCY    = 64,
  parameter int UNLOCK_ERRS    = 4,
  parameter int CNT_WIDTH      = 16,
  parameter int LAT_W          = $clog2(MAX_LATENCY+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [DATA_BUS_WIDTH-1:0]    Data_in,
  input  logic [DATA_BUS_WIDTH-1:0]    Data_out,
  output logic                         locked,
  output logic [LAT_W-1:0]             latency,
  output logic [CNT_WIDTH-1:0]         pass_count,
  output logic [CNT_WIDTH-1:0]         fail_count,
  output logic                         err,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int ERR_W = $clog2(UNLOCK_ERRS+1);
  localparam logic [LAT_W-1:0] MAX_AGE = LAT_W'(MAX_LATENCY);
  localparam logic [ERR_W-1:0] LAST_ERR = ERR_W'(UNLOCK_ERRS-1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_BUS_WIDTH-1:0] word_q [DEPTH];
  logic [LAT_W-1:0]          age_q  [DEPTH];
  logic [PTR_W-1:0]          rd_ptr_q, wr_ptr_q;
  logic [OCC_W-1:0]          occ_q;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic [ERR_W-1:0]          cerr_q, cerr_d;
  logic [CNT_WIDTH-1:0]      pass_q, fail_q;
  logic                      err_q, ovf_q;

  logic             empty, full;
  logic             head_match;
  logic [LAT_W-1:0] head_age;
  logic             hit, miss, pop, push, drop;

  assign empty = (occ_q == '0);
  assign full  = (occ_q == FULL_OCC);

  // Stored age lags by one edge; the age seen at this edge is one more.
  assign head_age = (age_q[rd_ptr_q] == MAX_AGE) ?
                    MAX_AGE : age_q[rd_ptr_q] + 1'b1;

  assign head_match = (Data_out === word_q[rd_ptr_q]);

  assign pop  = hit | miss;
  assign push = enable & (~full | pop);
  assign drop = enable & full & ~pop;

  // Head-entry decision and lock/unlock transitions.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    cerr_d  = cerr_q;
    hit     = 1'b0;
    miss    = 1'b0;
    if (!empty) begin
      unique case (state_q)
        SEARCH: begin
          if (head_match) begin
            hit     = 1'b1;
            lat_d   = head_age;
            cerr_d  = '0;
            state_d = LOCKED;
          end else if (head_age == MAX_AGE) begin
            miss = 1'b1;
          end
        end
        LOCKED: begin
          if (head_age == lat_q) begin
            if (head_match) begin
              hit    = 1'b1;
              cerr_d = '0;
            end else begin
              miss = 1'b1;
              if (cerr_q == LAST_ERR) begin
                state_d = SEARCH;
                lat_d   = '0;
                cerr_d  = '0;
              end else begin
                cerr_d = cerr_q + 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM, counters, pointers and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      lat_q    <= '0;
      cerr_q   <= '0;
      pass_q   <= '0;
      fail_q   <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      cerr_q  <= cerr_d;
      err_q   <= miss;
      if (hit && pass_q != '1) begin
        pass_q <= pass_q + 1'b1;
      end
      if (miss && fail_q != '1) begin
        fail_q <= fail_q + 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        occ_q <= occ_q + 1'b1;
      end else if (pop && !push) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  // Ages advance every cycle, saturating; a new entry starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= (age_q[i] == MAX_AGE) ?
                    MAX_AGE : age_q[i] + 1'b1;
      end
      if (push) begin
        age_q[wr_ptr_q] <= '0;
      end
    end
  end

  // Word storage; contents are only meaningful below occupancy.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      word_q[wr_ptr_q] <= Data_in;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign latency    = lat_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign err        = err_q;
  assign overflow   = ovf_q;
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_phy_data_scoreboard.sv
// tb_phy_data_scoreboard: directed and random checks of the scoreboard
// against a timestamp-queue model.
module tb_phy_data_scoreboard;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int MAXL  = 64;
  localparam int UERR  = 4;
  localparam int CW    = 16;
  localparam int LW    = $clog2(MAXL+1);
  localparam int OW    = $clog2(DEPTH+1);
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] Data_in = '0;
  logic [DW-1:0] Data_out = '0;
  logic          locked, err, overflow;
  logic [LW-1:0] latency;
  logic [CW-1:0] pass_count, fail_count;
  logic [OW-1:0] occupancy;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int err_seen = 0;
  bit armed = 1'b0;
  logic [DW-1:0] hist [int];

  always #5 clk = ~clk;

  phy_data_scoreboard #(
    .DATA_BUS_WIDTH(DW),
    .DEPTH(DEPTH),
    .MAX_LATENCY(MAXL),
    .UNLOCK_ERRS(UERR),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .Data_in(Data_in),
    .Data_out(Data_out),
    .locked(locked),
    .latency(latency),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .err(err),
    .overflow(overflow),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [DW-1:0] w;
    int            t;
  } ent_t;

  ent_t mq[$];
  int   cyc = 0;
  bit   m_locked = 0;
  int   m_lat = 0;
  int   m_pass = 0;
  int   m_fail = 0;
  int   m_cerr = 0;
  bit   m_err = 0;
  bit   m_ovf = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", n, a, e, $time);
    end
  endtask

  // Model: each entry carries its push time; age is now minus that.
  always @(posedge clk) begin : model
    int age;
    bit popped, hit;
    cyc++;
    m_err = 0;
    if (rst) begin
      mq.delete();
      m_locked = 0;
      m_lat = 0;
      m_pass = 0;
      m_fail = 0;
      m_cerr = 0;
      m_ovf = 0;
    end else begin
      popped = 0;
      if (mq.size() > 0) begin
        age = cyc - mq[0].t;
        if (age > MAXL) age = MAXL;
        hit = (Data_out === mq[0].w);
        if (!m_locked) begin
          if (hit) begin
            popped = 1;
            if (m_pass < CMAX) m_pass++;
            m_lat = age;
            m_locked = 1;
            m_cerr = 0;
          end else if (age == MAXL) begin
            popped = 1;
            if (m_fail < CMAX) m_fail++;
            m_err = 1;
          end
        end else if (age == m_lat) begin
          popped = 1;
          if (hit) begin
            if (m_pass < CMAX) m_pass++;
            m_cerr = 0;
          end else begin
            if (m_fail < CMAX) m_fail++;
            m_err = 1;
            m_cerr++;
            if (m_cerr == UERR) begin
              m_locked = 0;
              m_lat = 0;
              m_cerr = 0;
            end
          end
        end
        if (popped) void'(mq.pop_front());
      end
      if (enable) begin
        if (mq.size() < DEPTH) mq.push_back('{Data_in, cyc});
        else m_ovf = 1;
      end
    end
  end

  // Every cycle: DUT outputs against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("locked", locked, m_locked);
      chk("latency", latency, m_lat);
      chk("pass_count", pass_count, m_pass);
      chk("fail_count", fail_count, m_fail);
      chk("err", err, m_err);
      chk("overflow", overflow, m_ovf);
      chk("occupancy", occupancy, mq.size());
    end
  end

  task automatic tick(input bit r, input bit en,
                      input logic [DW-1:0] din,
                      input logic [DW-1:0] dout);
    rst = r;
    enable = en;
    Data_in = din;
    Data_out = dout;
    if (en) hist[edge_n + 1] = din;
    @(posedge clk);
    #1;
    edge_n++;
    if (err === 1'b1) err_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, '0);
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_locked"}, locked, 0);
    chk({n, "_latency"}, latency, 0);
    chk({n, "_pass"}, pass_count, 0);
    chk({n, "_fail"}, fail_count, 0);
    chk({n, "_err"}, err, 0);
    chk({n, "_ovf"}, overflow, 0);
    chk({n, "_occ"}, occupancy, 0);
  endtask

  initial begin
    tick(1, 0, '0, '0);
    armed = 1'b1;
    chk_zero("reset");

    // First lock at latency 3.
    err_seen = 0;
    tick(0, 1, 32'hA5A5A5A5, '0);
    idle(2);
    tick(0, 0, '0, 32'hA5A5A5A5);
    chk("s1_locked", locked, 1);
    chk("s1_latency", latency, 3);
    chk("s1_pass", pass_count, 1);
    chk("s1_occ", occupancy, 0);
    chk("s1_errs", err_seen, 0);

    // Five words, third one corrupted on the way back.
    err_seen = 0;
    for (int c = 0; c < 8; c++) begin
      logic [DW-1:0] dout;
      dout = '0;
      if (c >= 3) dout = (c == 5) ? 32'hDEAD0003 : DW'(c - 2);
      tick(0, c < 5, DW'(c + 1), dout);
    end
    chk("s2_pass", pass_count, 5);
    chk("s2_fail", fail_count, 1);
    chk("s2_errs", err_seen, 1);
    chk("s2_locked", locked, 1);

    // Four consecutive bad echoes drop the lock.
    err_seen = 0;
    for (int c = 0; c < 7; c++) begin
      tick(0, c < 4, DW'(32'h10 + c), (c >= 3) ? 32'hBAD0 : '0);
      if (c == 5) chk("s3_still_locked", locked, 1);
    end
    chk("s3_fail", fail_count, 5);
    chk("s3_locked", locked, 0);
    chk("s3_latency", latency, 0);
    chk("s3_errs", err_seen, 4);
    tick(0, 1, 32'h77, '0);
    idle(4);
    tick(0, 0, '0, 32'h77);
    chk("s3_relock", locked, 1);
    chk("s3_relat", latency, 5);
    chk("s3_pass", pass_count, 6);

    // Timeout exactly at MAX_LATENCY.
    tick(1, 0, '0, '0);
    chk_zero("rst2");
    tick(0, 1, 32'hCAFE, '0);
    idle(MAXL - 1);
    chk("s4_pre_fail", fail_count, 0);
    chk("s4_pre_occ", occupancy, 1);
    tick(0, 0, '0, '0);
    chk("s4_fail", fail_count, 1);
    chk("s4_err", err, 1);
    chk("s4_occ", occupancy, 0);
    chk("s4_locked", locked, 0);

    // Overflow on the ninth push; dropped word never counted.
    tick(1, 0, '0, '0);
    for (int i = 0; i < 9; i++) begin
      tick(0, 1, DW'(32'h100 + i), '0);
      if (i == 7) begin
        chk("s5_occ8", occupancy, 8);
        chk("s5_ovf8", overflow, 0);
      end
    end
    chk("s5_occ9", occupancy, 8);
    chk("s5_ovf9", overflow, 1);
    idle(70);
    chk("s5_fail", fail_count, 8);
    chk("s5_drain", occupancy, 0);

    // Pop and push together on a full queue.
    tick(1, 0, '0, '0);
    for (int i = 0; i < 8; i++) tick(0, 1, DW'(32'h200 + i), '0);
    tick(0, 1, 32'h2FF, 32'h200);
    chk("s5b_occ", occupancy, 8);
    chk("s5b_ovf", overflow, 0);
    chk("s5b_lat", latency, 8);

    // Reset with words queued while locked.
    tick(1, 0, '0, '0);
    for (int i = 0; i < 4; i++) tick(0, 1, DW'(32'h300 + i), '0);
    tick(0, 1, 32'h304, 32'h300);
    chk("s6_locked", locked, 1);
    chk("s6_occ", occupancy, 4);
    tick(1, 1, 32'h999, '0);
    chk_zero("s6_rst");
    tick(0, 1, 32'h400, '0);
    tick(0, 0, '0, '0);
    tick(0, 0, '0, 32'h400);
    chk("s6_locked2", locked, 1);
    chk("s6_lat2", latency, 2);
    chk("s6_pass", pass_count, 1);
    chk("s6_fail", fail_count, 0);

    // Random traffic with a shifting echo latency.
    tick(1, 0, '0, '0);
    for (int blk = 0; blk < 10; blk++) begin
      int lat, dens;
      lat = $urandom_range(1, 70);
      dens = $urandom_range(1, 4);
      for (int c = 0; c < 300; c++) begin
        bit en, r;
        int tgt;
        logic [DW-1:0] din, dout;
        en = ($urandom_range(0, 3) < dens);
        din = $urandom;
        tgt = edge_n + 1 - lat;
        if (hist.exists(tgt) && $urandom_range(0, 5) != 0) begin
          dout = hist[tgt];
          if ($urandom_range(0, 7) == 0) dout = dout ^ 32'h1;
        end else begin
          dout = DW'($urandom_range(0, 3));
        end
        r = (blk == 5 && c == 0) || ($urandom_range(0, 999) == 0);
        tick(r, en, din, dout);
      end
    end

    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
